// File: rtl/spi_clk_burst_if.sv
// spi_clk_burst_if: handshake, configuration and strobe bundle between the
// SPI controller (master) and the SCK burst generator (slave).
//   div/cpol/cpha/nbits : burst configuration, latched by the generator at start
//   start/stall         : burst request and back-pressure
//   busy/done           : burst in progress / one-cycle end-of-burst pulse
//   sck                 : registered SPI clock
//   lead_stb/trail_stb  : first cycle of the active / idle SCK level
//   shift_stb/sample_stb: shift-register strobes mapped from the edges via cpha
//   bit_idx             : current bit number of the burst
interface spi_clk_burst_if #(
    parameter int unsigned DIV_SIZE = 8,
    parameter int unsigned CNT_SIZE = 6
);
    logic [DIV_SIZE-1:0] div;
    logic                cpol;
    logic                cpha;
    logic [CNT_SIZE-1:0] nbits;
    logic                start;
    logic                stall;
    logic                busy;
    logic                done;
    logic                sck;
    logic                lead_stb;
    logic                trail_stb;
    logic                shift_stb;
    logic                sample_stb;
    logic [CNT_SIZE-1:0] bit_idx;

    modport master (
        output div, cpol, cpha, nbits, start, stall,
        input  busy, done, sck, lead_stb, trail_stb, shift_stb, sample_stb, bit_idx
    );

    modport slave (
        input  div, cpol, cpha, nbits, start, stall,
        output busy, done, sck, lead_stb, trail_stb, shift_stb, sample_stb, bit_idx
    );
endinterface

// File: rtl/spi_clk_burst.sv
// spi_clk_burst: fully synchronous SCK burst generator.
// SCK period is div+2 clk_in cycles (odd ratios allowed); each period spends
// ceil(P/2) cycles at the idle level then floor(P/2) at the active level.
// Emits nbits+1 periods per burst followed by a ceil(P/2) idle hold, then a
// one-cycle done pulse. stall freezes the burst in place.
// Ports:
//   clk_in : system clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : spi_clk_burst_if slave modport (config, handshake, sck, strobes)
module spi_clk_burst #(
    parameter int unsigned DIV_SIZE = 8,
    parameter int unsigned CNT_SIZE = 6
) (
    input  logic           clk_in,
    input  logic           rst,
    spi_clk_burst_if.slave bus
);
    localparam int unsigned PW = DIV_SIZE + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_TRAIL} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ph, ph_nxt;
    logic [PW-1:0]       cfg_pm1;   // P-1
    logic [PW-1:0]       cfg_l;     // ceil(P/2)
    logic                cfg_cpol;
    logic                cfg_cpha;
    logic [CNT_SIZE-1:0] cfg_nbits;
    logic [CNT_SIZE-1:0] bit_q, bit_nxt;
    logic                sck_q, sck_nxt;
    logic                lead_q, lead_nxt;
    logic                trail_q, trail_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic [PW:0]         l_calc;
    logic                accept;
    logic                ph_wrap;
    logic                last_bit;
    logic                hold_end;

    // ceil((div+2)/2) = (div+3)>>1, one extra bit so div=all-ones cannot overflow
    assign l_calc   = ({2'b00, bus.div} + (PW+1)'(3)) >> 1;
    // start is ignored in the done cycle even though the FSM is already IDLE
    assign accept   = (state == S_IDLE) && bus.start && !done_q;
    assign ph_wrap  = (ph == cfg_pm1);
    assign last_bit = (bit_q == cfg_nbits);
    assign hold_end = (ph == cfg_l - PW'(1));

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ACTIVE;
            S_ACTIVE: if (!bus.stall && ph_wrap && last_bit) state_nxt = S_TRAIL;
            S_TRAIL:  if (!bus.stall && hold_end) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ph_nxt    = ph;
        bit_nxt   = bit_q;
        sck_nxt   = sck_q;
        lead_nxt  = 1'b0;
        trail_nxt = 1'b0;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                sck_nxt = bus.cpol;
                if (accept) begin
                    ph_nxt   = '0;
                    bit_nxt  = '0;
                    busy_nxt = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!bus.stall) begin
                    ph_nxt = ph_wrap ? '0 : ph + PW'(1);
                    if (ph_wrap && !last_bit) bit_nxt = bit_q + CNT_SIZE'(1);
                    // phase 0..L-1 idle level, L..P-1 active level
                    sck_nxt   = (ph_nxt >= cfg_l) ? ~cfg_cpol : cfg_cpol;
                    lead_nxt  = (ph_nxt == cfg_l);
                    trail_nxt = ph_wrap;
                end
            end
            S_TRAIL: begin
                sck_nxt = cfg_cpol;
                if (!bus.stall) begin
                    if (hold_end) begin
                        ph_nxt   = '0;
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        ph_nxt = ph + PW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            ph        <= '0;
            cfg_pm1   <= '0;
            cfg_l     <= '0;
            cfg_cpol  <= 1'b0;
            cfg_cpha  <= 1'b0;
            cfg_nbits <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ph      <= ph_nxt;
            bit_q   <= bit_nxt;
            sck_q   <= sck_nxt;
            lead_q  <= lead_nxt;
            trail_q <= trail_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            if (accept) begin
                cfg_pm1   <= {1'b0, bus.div} + PW'(1);
                cfg_l     <= l_calc[PW-1:0];
                cfg_cpol  <= bus.cpol;
                cfg_cpha  <= bus.cpha;
                cfg_nbits <= bus.nbits;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sck       = sck_q;
    assign bus.lead_stb  = lead_q;
    assign bus.trail_stb = trail_q;
    assign bus.bit_idx   = bit_q;
    // The final trail edge is the only one seen in S_TRAIL, so it is the one
    // whose shift is suppressed in cpha=0 mode.
    assign bus.shift_stb  = cfg_cpha ? lead_q : (trail_q && (state != S_TRAIL));
    assign bus.sample_stb = cfg_cpha ? trail_q : lead_q;
endmodule

// File: tb/tb_spi_clk_burst.sv
// tb_spi_clk_burst: randomized and directed bench for spi_clk_burst. A
// timeline model derives every output from the burst's elapsed unstalled
// time using the period arithmetic of the SCK burst.
module tb_spi_clk_burst;
    localparam int unsigned DS = 8;
    localparam int unsigned CS = 6;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    spi_clk_burst_if #(.DIV_SIZE(DS), .CNT_SIZE(CS)) bus ();

    spi_clk_burst #(.DIV_SIZE(DS), .CNT_SIZE(CS)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // timeline model state
    bit m_busy = 0, m_done = 0, m_fresh = 0, m_sck = 0, m_cpol = 0, m_cpha = 0;
    int m_e = 0, m_p = 2, m_l = 1, m_n = 0, m_bit = 0;

    // per-burst observation for directed checks
    int cyc = 0, done_at = -1, n_sample = 0, n_shift = 0, n_busy = 0;
    int trail_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit i_rst, i_start, i_stall, i_cpol, i_cpha, e_lead, e_trail, e_shift, e_sample, last;
        int i_div, i_nb, u, span, k, r;
        i_rst = rst; i_start = bus.start; i_stall = bus.stall;
        i_cpol = bus.cpol; i_cpha = bus.cpha; i_div = int'(bus.div); i_nb = int'(bus.nbits);
        @(posedge clk_in);
        #1;
        cyc++;
        if (i_rst) begin
            m_busy = 0; m_done = 0; m_fresh = 0; m_sck = 0; m_bit = 0;
        end else if (!m_busy) begin
            if (i_start && !m_done) begin
                m_busy = 1; m_e = 1; m_fresh = 1;
                m_p = i_div + 2; m_l = (m_p + 1) / 2; m_n = i_nb;
                m_cpol = i_cpol; m_cpha = i_cpha;
            end
            m_sck  = i_cpol;
            m_done = 0;
        end else begin
            if (i_stall) m_fresh = 0;
            else begin m_e++; m_fresh = 1; end
            if (m_e - 1 == (m_n + 1) * m_p + m_l) begin
                m_busy = 0; m_done = 1; m_sck = m_cpol;
            end
        end
        e_lead = 0; e_trail = 0; e_shift = 0; e_sample = 0;
        if (m_busy) begin
            u = m_e - 1;
            span = (m_n + 1) * m_p;
            last = (u == span);
            if (u < span) begin
                k = u / m_p; r = u % m_p;
                m_sck   = (r >= m_l) ? !m_cpol : m_cpol;
                m_bit   = k;
                e_lead  = m_fresh && (r == m_l);
                e_trail = m_fresh && (r == 0) && (k >= 1);
            end else begin
                m_sck   = m_cpol;
                m_bit   = m_n;
                e_trail = m_fresh && last;
            end
            e_shift  = m_cpha ? e_lead  : (e_trail && !last);
            e_sample = m_cpha ? e_trail : e_lead;
        end
        check("busy",   32'(bus.busy),       32'(m_busy));
        check("done",   32'(bus.done),       32'(m_done));
        check("sck",    32'(bus.sck),        32'(m_sck));
        check("lead",   32'(bus.lead_stb),   32'(e_lead));
        check("trail",  32'(bus.trail_stb),  32'(e_trail));
        check("shift",  32'(bus.shift_stb),  32'(e_shift));
        check("sample", 32'(bus.sample_stb), 32'(e_sample));
        check("bit_idx", 32'(bus.bit_idx),   32'(m_bit));
        if (bus.done) done_at = cyc;
        if (bus.sample_stb) n_sample++;
        if (bus.shift_stb) n_shift++;
        if (bus.busy) n_busy++;
        if (bus.trail_stb) trail_cyc.push_back(cyc);
    endtask

    // Current cycle becomes cycle 0 with start asserted.
    task automatic begin_burst(input int dv, input bit cp, input bit ch, input int nb);
        bus.div = DS'(dv); bus.cpol = cp; bus.cpha = ch; bus.nbits = CS'(nb);
        bus.start = 1'b1;
        cyc = 0; done_at = -1; n_sample = 0; n_shift = 0; n_busy = 0;
        trail_cyc.delete();
    endtask

    task automatic run(input int ncyc, input int st_lo, input int st_hi);
        for (int i = 0; i < ncyc; i++) begin
            bus.stall = (cyc >= st_lo) && (cyc <= st_hi);
            step();
            bus.start = 1'b0;
        end
        bus.stall = 1'b0;
    endtask

    initial begin
        bus.div = '0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.nbits = '0;
        bus.start = 1'b0; bus.stall = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // mode 0 basic
        begin_burst(2, 0, 0, 7);
        run(40, -1, -1);
        check("m0_done_at", 32'(done_at), 32'd35);
        check("m0_samples", 32'(n_sample), 32'd8);
        check("m0_shifts",  32'(n_shift),  32'd7);
        check("m0_busy_cycles", 32'(n_busy), 32'd34);

        // odd ratio, cpol=1
        begin_burst(1, 1, 0, 0);
        run(10, -1, -1);
        check("odd_done_at", 32'(done_at), 32'd6);
        check("odd_trail_n", 32'(trail_cyc.size()), 32'd1);
        if (trail_cyc.size() > 0) check("odd_trail_at", 32'(trail_cyc[0]), 32'd4);

        // mode 3
        begin_burst(0, 1, 1, 3);
        run(14, -1, -1);
        check("m3_shifts",  32'(n_shift),  32'd4);
        check("m3_samples", 32'(n_sample), 32'd4);

        // stall
        begin_burst(2, 0, 0, 1);
        run(20, 4, 8);
        check("stall_done_at", 32'(done_at), 32'd16);
        check("stall_trail_n", 32'(trail_cyc.size()), 32'd2);
        if (trail_cyc.size() == 2) begin
            check("stall_trail0", 32'(trail_cyc[0]), 32'd10);
            check("stall_trail1", 32'(trail_cyc[1]), 32'd14);
        end

        // reset mid-burst, restart at cycle 12
        begin_burst(2, 0, 0, 7);
        run(10, -1, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_no_done", 32'(done_at), 32'hFFFF_FFFF);
        step();
        begin_burst(2, 0, 0, 7);
        run(40, -1, -1);
        check("rst_restart_done_at", 32'(done_at), 32'd35);

        // widest period
        begin_burst(255, 0, 1, 0);
        run(400, 100, 102);
        check("wide_done_at", 32'(done_at), 32'd390);

        // start held high, config churn mid-burst
        bus.start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.div = DS'($urandom_range(0, 3));
            bus.nbits = CS'($urandom_range(0, 1));
            bus.cpol = 1'($urandom); bus.cpha = 1'($urandom);
            if (i < 20) begin bus.div = '0; bus.nbits = '0; end
            step();
        end
        bus.start = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.div   = DS'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6));
            bus.nbits = CS'($urandom_range(0, 5));
            bus.cpol  = 1'($urandom);
            bus.cpha  = 1'($urandom);
            step();
        end
        rst = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
